// File: rtl/param_shift_engine_if.sv
// Handshake and data bundle for param_shift_engine: operation request signals
// from the controller (master) and working register/status from the engine (slave).
interface param_shift_engine_if #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH) + 1
);
   logic             start;
   logic [2:0]       mode;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] d;
   logic             ser_in;
   logic [WIDTH-1:0] q;
   logic             ser_out;
   logic             busy;
   logic             done;

   modport master (
      output start, mode, shamt, d, ser_in,
      input  q, ser_out, busy, done
   );

   modport slave (
      input  start, mode, shamt, d, ser_in,
      output q, ser_out, busy, done
   );
endinterface

// File: rtl/param_shift_engine.sv
// Multi-cycle universal shift engine: loads a word, then applies one 1-bit
// shift/rotate/serial step per clock for a clamped amount, ending with a done pulse.
module param_shift_engine #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   param_shift_engine_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] q_q;
   logic             ser_out_q;
   logic             busy_q;
   logic             done_q;
   logic [2:0]       mode_q;
   logic [SHW-1:0]   cnt_q;

   logic [WIDTH-1:0] step_d;
   logic             step_ser_d;
   logic [SHW-1:0]   cnt_start_d;

   // Clamp requested amount so that anything beyond WIDTH behaves as WIDTH.
   always_comb begin
      cnt_start_d = bus.shamt;
      if (bus.shamt > SHW'(WIDTH)) begin
         cnt_start_d = SHW'(WIDTH);
      end else begin
         cnt_start_d = bus.shamt;
      end
   end

   // One 1-bit step of the latched mode; reserved code leaves q and ser_out untouched.
   always_comb begin
      step_d     = q_q;
      step_ser_d = ser_out_q;
      case (mode_q)
         3'b000: begin step_d = {1'b0, q_q[WIDTH-1:1]};          step_ser_d = q_q[0];       end
         3'b001: begin step_d = {q_q[WIDTH-2:0], 1'b0};          step_ser_d = q_q[WIDTH-1]; end
         3'b010: begin step_d = {q_q[0], q_q[WIDTH-1:1]};        step_ser_d = q_q[0];       end
         3'b011: begin step_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};  step_ser_d = q_q[WIDTH-1]; end
         3'b100: begin step_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};  step_ser_d = q_q[0];       end
         3'b101: begin step_d = {bus.ser_in, q_q[WIDTH-1:1]};    step_ser_d = q_q[0];       end
         3'b110: begin step_d = {q_q[WIDTH-2:0], bus.ser_in};    step_ser_d = q_q[WIDTH-1]; end
         default: begin step_d = q_q;                             step_ser_d = ser_out_q;    end
      endcase
   end

   // Control FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         q_q       <= {WIDTH{1'b0}};
         ser_out_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         mode_q    <= 3'b000;
         cnt_q     <= {SHW{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  q_q    <= bus.d;
                  mode_q <= bus.mode;
                  cnt_q  <= cnt_start_d;
                  busy_q <= 1'b1;
                  if (cnt_start_d == {SHW{1'b0}}) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_SHIFT;
                     done_q  <= 1'b0;
                  end
               end else begin
                  busy_q <= 1'b0;
                  done_q <= 1'b0;
               end
            end
            S_SHIFT: begin
               q_q       <= step_d;
               ser_out_q <= step_ser_d;
               cnt_q     <= cnt_q - SHW'(1);
               // The edge that consumes the last count is also the final shift.
               if (cnt_q == SHW'(1)) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= S_SHIFT;
                  done_q  <= 1'b0;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               cnt_q   <= {SHW{1'b0}};
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               cnt_q   <= {SHW{1'b0}};
            end
         endcase
      end
   end

   assign bus.q       = q_q;
   assign bus.ser_out = ser_out_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;

endmodule

// File: tb/tb_param_shift_engine.sv
// Self-checking bench for param_shift_engine (WIDTH=8): directed scenarios plus
// random operations checked against an arithmetic reference model.
module tb_param_shift_engine;
   localparam int W  = 8;
   localparam int SW = $clog2(W) + 1;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   logic exp_ser;

   param_shift_engine_if #(.WIDTH(W), .SHW(SW)) bus ();

   param_shift_engine #(.WIDTH(W), .SHW(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: whole-operation result from arithmetic on the operand.
   // sbits[i] is the ser_in value presented for shift step i.
   function automatic void model(input int mode, input int shamt, input logic [W-1:0] d,
                                 input logic [W-1:0] sbits, input logic prev,
                                 output logic [W-1:0] rq, output logic rs);
      logic [63:0] dv, mask, sv, r;
      int k;
      k    = (shamt > W) ? W : shamt;
      dv   = 64'(d);
      mask = (64'd1 << W) - 64'd1;
      rq   = d;
      rs   = prev;
      if (k == 0 || mode == 7) return;
      sv = 64'd0;
      r  = dv;
      case (mode)
         0: r = dv >> k;
         1: r = dv << k;
         2: r = (dv >> k) | (dv << (W - k));
         3: r = (dv << k) | (dv >> (W - k));
         4: r = d[W-1] ? ((dv >> k) | (mask & ~(mask >> k))) : (dv >> k);
         5: begin
            for (int i = 0; i < k; i++) sv = sv | (64'(sbits[i]) << i);
            r = (dv >> k) | (sv << (W - k));
         end
         default: begin
            for (int i = 0; i < k; i++) sv = sv | (64'(sbits[i]) << (k - 1 - i));
            r = (dv << k) | sv;
         end
      endcase
      rq = W'(r & mask);
      rs = (mode == 1 || mode == 3 || mode == 6) ? d[W-k] : d[k-1];
   endfunction

   // Issues one operation from a negedge-aligned point and observes it until busy drops.
   task automatic run_op(input int mode, input int shamt, input logic [W-1:0] d,
                         input logic [W-1:0] sbits, input int inj,
                         output logic [W-1:0] oq, output logic os,
                         output int busy_cnt, output int done_cnt, output int done_cyc,
                         output bit timeout);
      oq = '0; os = 1'b0; busy_cnt = 0; done_cnt = 0; done_cyc = 0; timeout = 1'b1;
      bus.start  = 1'b1;
      bus.mode   = 3'(mode);
      bus.shamt  = SW'(shamt);
      bus.d      = d;
      bus.ser_in = sbits[0];
      @(posedge clk);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
         if (bus.done) begin
            done_cnt++;
            done_cyc = c;
            oq = bus.q;
            os = bus.ser_out;
         end
         if (!bus.busy) begin
            bus.start = 1'b0;
            timeout   = 1'b0;
            break;
         end
         bus.start  = (c == inj);
         if (c == inj) bus.d = ~d;
         bus.ser_in = (c - 1 < W) ? sbits[c-1] : 1'b0;
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.start = 1'b0; bus.mode = 3'b000; bus.shamt = '0; bus.d = '0; bus.ser_in = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (bus.q !== 8'h00) begin bad++; $display("FAIL reset_q: got %h want 00", bus.q); end
      total++; if ({bus.busy, bus.done, bus.ser_out} !== 3'b000) begin bad++;
         $display("FAIL reset_flags: got busy/done/ser %b want 000", {bus.busy, bus.done, bus.ser_out}); end
      rst = 1'b1;
      exp_ser = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_op();
      bus.start = 1'b1; bus.mode = 3'b000; bus.shamt = SW'(6); bus.d = 8'hFF;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      total++; if (bus.q !== 8'h7F || bus.ser_out !== 1'b1 || bus.busy !== 1'b1) begin bad++;
         $display("FAIL midop_pre: got q=%h ser=%b busy=%b want 7F 1 1", bus.q, bus.ser_out, bus.busy); end
      #2 rst = 1'b0;
      #1;
      total++; if (bus.q !== 8'h00) begin bad++; $display("FAIL midop_rst_q: got %h want 00", bus.q); end
      total++; if ({bus.busy, bus.done, bus.ser_out} !== 3'b000) begin bad++;
         $display("FAIL midop_rst_flags: got %b want 000", {bus.busy, bus.done, bus.ser_out}); end
      @(negedge clk);
      rst = 1'b1;
      exp_ser = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.q !== 8'h00) begin bad++;
         $display("FAIL midop_idle: got busy=%b done=%b q=%h want 0 0 00", bus.busy, bus.done, bus.q); end
   endtask

   task automatic test_lsr();
      logic [W-1:0] oq; logic os; int bc, dc, dcy; bit to;
      run_op(0, 3, 8'hB5, 8'h00, 2, oq, os, bc, dc, dcy, to);
      exp_ser = 1'b1;
      total++; if (oq !== 8'h16 || os !== 1'b1) begin bad++;
         $display("FAIL lsr_result: got q=%h ser=%b want 16 1", oq, os); end
      total++; if (bc !== 4 || dc !== 1 || dcy !== 4 || to) begin bad++;
         $display("FAIL lsr_timing: got busy=%0d dones=%0d at=%0d to=%0d want 4 1 4 0", bc, dc, dcy, to); end
      total++; if (bus.q !== 8'h16) begin bad++; $display("FAIL lsr_hold: got %h want 16", bus.q); end
   endtask

   task automatic test_rotate();
      logic [W-1:0] oq; logic os; int bc, dc, dcy; bit to;
      run_op(3, 1, 8'h81, 8'h00, 0, oq, os, bc, dc, dcy, to);
      total++; if (oq !== 8'h03 || os !== 1'b1 || dcy !== 2) begin bad++;
         $display("FAIL rol1: got q=%h ser=%b at=%0d want 03 1 2", oq, os, dcy); end
      run_op(2, 8, 8'h81, 8'h00, 0, oq, os, bc, dc, dcy, to);
      total++; if (oq !== 8'h81 || os !== 1'b1 || bc !== 9) begin bad++;
         $display("FAIL ror8: got q=%h ser=%b busy=%0d want 81 1 9", oq, os, bc); end
      exp_ser = 1'b1;
   endtask

   task automatic test_asr();
      logic [W-1:0] oq; logic os; int bc, dc, dcy; bit to;
      run_op(4, 2, 8'h90, 8'h00, 0, oq, os, bc, dc, dcy, to);
      total++; if (oq !== 8'hE4 || os !== 1'b0) begin bad++;
         $display("FAIL asr2: got q=%h ser=%b want E4 0", oq, os); end
      run_op(4, 12, 8'h90, 8'h00, 0, oq, os, bc, dc, dcy, to);
      total++; if (oq !== 8'hFF || os !== 1'b1) begin bad++;
         $display("FAIL asr_clamp: got q=%h ser=%b want FF 1", oq, os); end
      total++; if (bc !== 9 || dcy !== 9 || dc !== 1) begin bad++;
         $display("FAIL asr_clamp_timing: got busy=%0d at=%0d dones=%0d want 9 9 1", bc, dcy, dc); end
      exp_ser = 1'b1;
   endtask

   task automatic test_serial();
      logic [W-1:0] oq; logic os; int bc, dc, dcy; bit to;
      run_op(6, 4, 8'h00, 8'b0000_1101, 0, oq, os, bc, dc, dcy, to);
      total++; if (oq !== 8'h0B || os !== 1'b0 || dcy !== 5) begin bad++;
         $display("FAIL ser_left: got q=%h ser=%b at=%0d want 0B 0 5", oq, os, dcy); end
      exp_ser = 1'b0;
   endtask

   task automatic test_zero_and_reserved();
      logic [W-1:0] oq; logic os; int bc, dc, dcy; bit to;
      run_op(int'($urandom_range(0, 7)), 0, 8'h5A, 8'hFF, 0, oq, os, bc, dc, dcy, to);
      total++; if (oq !== 8'h5A || dcy !== 1 || bc !== 1 || os !== exp_ser) begin bad++;
         $display("FAIL zero_shamt: got q=%h at=%0d busy=%0d ser=%b want 5A 1 1 %b", oq, dcy, bc, os, exp_ser); end
      run_op(7, 5, 8'h3C, 8'hFF, 0, oq, os, bc, dc, dcy, to);
      total++; if (oq !== 8'h3C || dcy !== 6 || bc !== 6 || os !== exp_ser) begin bad++;
         $display("FAIL reserved: got q=%h at=%0d busy=%0d ser=%b want 3C 6 6 %b", oq, dcy, bc, os, exp_ser); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] oq, eq; logic os, es; int bc, dc, dcy; bit to;
      for (int i = 0; i < 2; i++) begin
         int m, s; logic [W-1:0] d;
         m = int'($urandom_range(0, 6)); s = int'($urandom_range(1, 8)); d = W'($urandom);
         model(m, s, d, 8'h00, exp_ser, eq, es);
         run_op(m, s, d, 8'h00, 0, oq, os, bc, dc, dcy, to);
         exp_ser = es;
         total++; if (oq !== eq || os !== es || dcy !== s + 1 || to) begin bad++;
            $display("FAIL b2b_%0d: got q=%h ser=%b at=%0d want %h %b %0d", i, oq, os, dcy, eq, es, s + 1); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] oq, eq, sb, d; logic os, es; int bc, dc, dcy, m, s, k, inj; bit to;
      for (int i = 0; i < 60; i++) begin
         m = int'($urandom_range(0, 7)); s = int'($urandom_range(0, 15));
         d = W'($urandom); sb = W'($urandom);
         k = (s > W) ? W : s;
         inj = (k >= 2) ? int'($urandom_range(2, k)) : 0;
         model(m, s, d, sb, exp_ser, eq, es);
         run_op(m, s, d, sb, inj, oq, os, bc, dc, dcy, to);
         exp_ser = es;
         total++; if (oq !== eq || os !== es) begin bad++;
            $display("FAIL rand_%0d_result: mode=%0d shamt=%0d d=%h got q=%h ser=%b want %h %b", i, m, s, d, oq, os, eq, es); end
         total++; if (bc !== k + 1 || dc !== 1 || dcy !== k + 1 || to) begin bad++;
            $display("FAIL rand_%0d_timing: got busy=%0d dones=%0d at=%0d to=%0d want %0d 1 %0d 0", i, bc, dc, dcy, to, k + 1, k + 1); end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      exp_ser = 1'b0;
      test_reset();
      test_reset_mid_op();
      test_lsr();
      test_rotate();
      test_asr();
      test_serial();
      test_zero_and_reserved();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/param_shift_engine.md
Name: param_shift_engine

Overview:
- Parametrised, multi-cycle universal shift engine; generalises the team's 8-bit single-step shift register.
- Loads a WIDTH-bit word and applies one of seven shift/rotate/serial modes by a programmable amount, one bit position per clock.
- Completion is signalled with a busy/done handshake.
- Sits between datapath registers and serial/bit-manipulation logic where an area-cheap alternative to a barrel shifter is needed.

Parameters:
- WIDTH, 8: data word width in bits, must be >= 2.
- SHW, $clog2(WIDTH)+1: width of shamt, so it can encode 0..WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- mode  input  3  operation select; latched on accepted start.
- shamt  input  SHW  shift amount; latched on accepted start.
- d  input  WIDTH  operand; loaded into q on accepted start.
- ser_in  input  1  fill bit for serial modes; sampled on every SHIFT edge.
- q  output  WIDTH  working/result register.
- ser_out  output  1  bit shifted out on the most recent shift edge.
- busy  output  1  high whenever state != IDLE.
- done  output  1  single-cycle pulse; q holds the final result.

Behaviour:
- Reset (rst=0, asynchronous, any state including mid-SHIFT):
  - state = IDLE; q = 0, ser_out = 0, busy = 0, done = 0.
  - Latched mode and remaining count cleared.
  - Operation in flight is discarded.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - On an edge with start=1: q <= d; latch mode; cnt <= min(shamt, WIDTH).
  - shamt > WIDTH is clamped to WIDTH.
  - Next state is DONE if the clamped count is 0, else SHIFT.
  - With start=0: hold q.
- SHIFT: each edge applies one 1-bit step per latched mode, cnt <= cnt-1. Moves to DONE on the edge where cnt==1, which is also the final shift.
- DONE: done=1 for exactly one cycle; q stable. Next edge returns to IDLE unconditionally.
- start is ignored in SHIFT and DONE. No queueing: a new start is accepted only once busy=0.
- Latency:
  - Start accepted at edge k; shifts occur at edges k+1..k+n, where n = clamped shamt.
  - done is high in the cycle after edge k+n; busy is high for n+1 cycles.
  - n=0: done in the cycle after edge k, with q=d.
- Modes, per 1-bit step on q, with ser_out <= the departing bit:
  - 000 LSR: q <= {0, q[W-1:1]}; ser_out <= q[0].
  - 001 LSL: q <= {q[W-2:0], 0}; ser_out <= q[W-1].
  - 010 ROR: q <= {q[0], q[W-1:1]}; ser_out <= q[0].
  - 011 ROL: q <= {q[W-2:0], q[W-1]}; ser_out <= q[W-1].
  - 100 ASR: q <= {q[W-1], q[W-1:1]}; ser_out <= q[0].
  - 101 serial-right: q <= {ser_in, q[W-1:1]}; ser_out <= q[0].
  - 110 serial-left: q <= {q[W-2:0], ser_in}; ser_out <= q[W-1].
  - 111 reserved: q unchanged, ser_out unchanged; count and timing still run normally.
- Wrap-around:
  - Rotate by WIDTH returns the original word.
  - LSR/LSL by WIDTH gives 0.
  - ASR by WIDTH gives all copies of the sign bit.
- ser_out is updated only on SHIFT edges and holds its value otherwise, including across start.
- start and rst deassertion in the same cycle: start is sampled at the first rising edge after rst=1.

Test Plan:
1. Reset mid-operation: WIDTH=8, LSR d=8'hFF shamt=6; drive rst=0 two cycles after start -> q=8'h00, busy=0, done=0, ser_out=0 immediately (no clock needed); IDLE after release.
2. LSR d=8'hB5 shamt=3 -> q=8'h16, ser_out=1. busy high 4 cycles; done pulses once, in the 4th cycle after the start edge. A start pulse mid-operation is ignored.
3. ROL d=8'h81 shamt=1 -> q=8'h03, ser_out=1. ROR d=8'h81 shamt=8 -> q=8'h81.
4. ASR d=8'h90 shamt=2 -> q=8'hE4. ASR d=8'h90 shamt=12 -> clamped to 8, q=8'hFF, busy 9 cycles.
5. Serial-left d=8'h00 shamt=4, ser_in=1,0,1,1 on successive SHIFT edges -> q=8'h0B, ser_out=0.
6. shamt=0 with any mode, d=8'h5A -> done in the next cycle, q=8'h5A. Mode 111 d=8'h3C shamt=5 -> q=8'h3C, done after 5 shift cycles. Back-to-back starts in consecutive IDLE cycles are both executed.
